// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between core MMIO writes and a UART transmitter.
// A drain FSM issues one tx_start per byte and waits for the UART to finish.
module uart_tx_fifo #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [7:0]                 push_data,
    output logic                       push_ready,
    input  logic                       flush,
    input  logic                       clear_overflow,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [TW-1:0]   tmo;
    logic [TW-1:0]   tmo_nxt;
    logic            do_push;
    logic            do_pop;
    logic            drop;

    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign push_ready = !full;
    assign tx_start   = (state == LOAD);

    // A flush swallows any push in the same cycle, including a dropped one.
    assign do_push = push_valid && !full && !flush;
    assign drop    = push_valid && full && !flush;
    assign do_pop  = (state == IDLE) && !empty && !tx_busy;

    // Byte storage; written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[tail] <= push_data;
        end
    end

    // Head/tail pointers and occupancy; flush empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + AW'(1);
            end
            if (do_pop) begin
                head <= head + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Head byte is captured into tx_data as it is popped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_data <= 8'h00;
        end else if (do_pop) begin
            tx_data <= mem[head];
        end
    end

    // Drain FSM state and busy-wait timeout counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            tmo   <= '0;
        end else begin
            state <= state_nxt;
            tmo   <= tmo_nxt;
        end
    end

    // Next state; the timeout counter only runs while waiting for busy.
    always_comb begin
        state_nxt = state;
        tmo_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (!empty && !tx_busy) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
